// File: rtl/aes_subbytes_engine_pkg.sv
// Shared types and S-box tables for the SubBytes/InvSubBytes engine.
// The forward table exists only when AES_SBOX_FWD_EN is defined.
package aes_subbytes_engine_pkg;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } aes_state_e;

`ifdef AES_SBOX_FWD_EN
  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
`endif

  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_subbytes_engine_if.sv
// Block stream interface of the SubBytes engine: one 128-bit state plus mode in,
// one 128-bit state out, each with its own valid/ready pair.
interface aes_subbytes_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_subbytes_engine_sbox_lane.sv
// One combinational S-box lane. With AES_SBOX_FWD_EN the lane selects forward or
// inverse by inv; without it the lane is inverse-only and inv is ignored.
module aes_subbytes_engine_sbox_lane
  import aes_subbytes_engine_pkg::*;
(
  input  aes_byte_t din,
  input  logic      inv,
  output aes_byte_t dout
);
`ifdef AES_SBOX_FWD_EN
  assign dout = inv ? INV_SBOX[din] : SBOX[din];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign dout       = INV_SBOX[din];
`endif
endmodule

// File: rtl/aes_subbytes_engine.sv
// Handshaked SubBytes/InvSubBytes engine substituting LANES bytes per clock.
// Define AES_SBOX_FWD_EN to build the forward S-box; otherwise the engine is inverse-only.
module aes_subbytes_engine
  import aes_subbytes_engine_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_subbytes_engine_if.slave bus,
  output logic                 busy
);
  localparam int NBEATS = 16 / LANES;
  localparam int CNTW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LW     = 8 * LANES;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NBEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_illegal
    $error("aes_subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  aes_state_e      state_reg;
  logic [127:0]    st_reg;
  logic [CNTW-1:0] cnt_reg;
  logic            mode_reg;
  logic            out_valid_reg;
  logic            busy_reg;
  logic [LW-1:0]   sub_bytes;
  logic [127:0]    rot_next;
  logic            accept;
  logic            accept_mode;

  // The top LANES bytes are substituted and re-enter at the bottom, so after
  // NBEATS beats every byte has been substituted once and is back in place.
  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    aes_subbytes_engine_sbox_lane u_lane (
      .din  (st_reg[128-LW+8*gi +: 8]),
      .inv  (mode_reg),
      .dout (sub_bytes[8*gi +: 8])
    );
  end

  if (LANES == 16) begin : g_rot_full
    assign rot_next = sub_bytes;
  end else begin : g_rot_part
    assign rot_next = {st_reg[127-LW:0], sub_bytes};
  end

`ifdef AES_SBOX_FWD_EN
  assign accept_mode = bus.in_inv;
`else
  logic unused_in_inv;
  assign unused_in_inv = bus.in_inv;
  assign accept_mode   = 1'b1;
`endif

  assign bus.in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = st_reg;
  assign busy          = busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      st_reg        <= '0;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            st_reg    <= bus.in_data;
            mode_reg  <= accept_mode;
            cnt_reg   <= '0;
            state_reg <= BUSY;
            busy_reg  <= 1'b1;
          end
        end
        BUSY: begin
          st_reg <= rot_next;
          if (cnt_reg == LAST_BEAT) begin
            cnt_reg       <= '0;
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNTW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            // Back-to-back hand-off: the next block loads on the same edge.
            if (accept) begin
              st_reg    <= bus.in_data;
              mode_reg  <= accept_mode;
              cnt_reg   <= '0;
              state_reg <= BUSY;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Directed and streaming bench for aes_subbytes_engine (LANES=1); reference S-boxes are
// derived from GF(2^8) arithmetic. Honours AES_SBOX_FWD_EN like the design.
module tb_aes_subbytes_engine;
  localparam int LANES   = 1;
  localparam int NBEATS  = 16 / LANES;
  localparam int NSTREAM = 20;
`ifdef AES_SBOX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  aes_subbytes_engine_if bus ();

  aes_subbytes_engine #(.LANES(LANES)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] ref_fwd(input logic [7:0] a);
    logic [7:0] b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a block from IDLE, wait for the accept edge, then scramble the inputs.
  task automatic accept_block(input string tag, input logic [127:0] d, input logic inv);
    int guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_inv   = inv;
    #1;
    while (!bus.in_ready && guard < 64) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk_bit({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_inv   = ~inv;
    chk_bit({tag, "_busy"}, busy, 1'b1);
    chk_bit({tag, "_ready_in_busy"}, bus.in_ready, 1'b0);
  endtask

  // Edges from the accepting edge until out_valid is seen, -1 if never.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int e = 1; e <= 4 * NBEATS + 8; e++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk_bit({tag, "_valid_drop"}, bus.out_valid, 1'b0);
    $display("[TB] %s block delivered", tag);
  endtask

  initial begin
    logic [127:0] blk  [NSTREAM];
    logic         md   [NSTREAM];
    logic [127:0] expv [NSTREAM];
    int lat;
    int n_in;
    int n_out;
    int cyc;
    bit seen;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_inv    = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      fwd_t[i] = ref_fwd(8'(i));
      inv_t[i] = ref_inv(8'(i));
    end

    // T1 reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit("t1_out_valid", bus.out_valid, 1'b0);
    chk_bit("t1_busy", busy, 1'b0);
    chk("t1_out_data", bus.out_data, 128'h0);
    chk_bit("t1_in_ready", bus.in_ready, 1'b1);

`ifdef AES_SBOX_FWD_EN
    // T2 forward
    accept_block("t2", 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    wait_done(lat);
    chk_int("t2_latency", lat, NBEATS);
    chk("t2_data", bus.out_data, 128'h637c777bf26b6fc53001672bfed7ab76);
    drain("t2");
`endif

    // T3 inverse
    accept_block("t3", 128'h637c777bf26b6fc53001672bfed7ab76, 1'b1);
    wait_done(lat);
    chk_int("t3_latency", lat, NBEATS);
    chk("t3_data", bus.out_data, 128'h000102030405060708090a0b0c0d0e0f);
    drain("t3");
`ifndef AES_SBOX_FWD_EN
    accept_block("t3b", 128'h637c777bf26b6fc53001672bfed7ab76, 1'b0);
    wait_done(lat);
    chk_int("t3b_latency", lat, NBEATS);
    chk("t3b_data", bus.out_data, 128'h000102030405060708090a0b0c0d0e0f);
    drain("t3b");
`endif

    // T4 backpressure, then same-edge hand-off to the next block
    accept_block("t4", {16{8'hca}}, 1'b1);
    wait_done(lat);
    chk_int("t4_latency", lat, NBEATS);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 128'h637c777bf26b6fc53001672bfed7ab76;
      bus.in_inv   = 1'b1;
      #1;
      chk_bit("t4_hold_valid", bus.out_valid, 1'b1);
      chk("t4_hold_data", bus.out_data, {16{8'h10}});
      chk_bit("t4_hold_in_ready", bus.in_ready, 1'b0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk_bit("t4_handoff_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    chk_bit("t4_next_busy", busy, 1'b1);
    chk_bit("t4_next_valid_low", bus.out_valid, 1'b0);
    $display("[TB] t4 block delivered");
    wait_done(lat);
    chk_int("t4_next_latency", lat, NBEATS);
    chk("t4_next_data", bus.out_data, 128'h000102030405060708090a0b0c0d0e0f);
    drain("t4_next");

    // T5 reset at beat 7 discards the block
    accept_block("t5", 128'h0123456789abcdeffedcba9876543210, 1'b1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit("t5_busy", busy, 1'b0);
    chk_bit("t5_out_valid", bus.out_valid, 1'b0);
    chk("t5_out_data", bus.out_data, 128'h0);
    chk_bit("t5_in_ready", bus.in_ready, 1'b1);
    seen = 1'b0;
    repeat (NBEATS + 4) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk_bit("t5_no_output", seen, 1'b0);
    accept_block("t5b", {16{8'h63}}, 1'b1);
    wait_done(lat);
    chk_int("t5b_latency", lat, NBEATS);
    chk("t5b_data", bus.out_data, 128'h0);
    drain("t5b");

    // T6 streaming with random valid/ready
    for (int i = 0; i < NSTREAM; i++) begin
      blk[i]  = {$urandom, $urandom, $urandom, $urandom};
      md[i]   = 1'($urandom_range(0, 1));
      expv[i] = ref_block(blk[i], FWD ? md[i] : 1'b1);
    end
    n_in  = 0;
    n_out = 0;
    cyc   = 0;
    while (n_out < NSTREAM && cyc < 4000) begin
      @(negedge clk);
      if (n_in < NSTREAM) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = blk[n_in];
        bus.in_inv   = md[n_in];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        $display("[TB] stream out %0d data %h", n_out, bus.out_data);
        chk("t6_stream_data", bus.out_data, expv[n_out]);
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) n_in++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk_int("t6_blocks_out", n_out, NSTREAM);
    chk_int("t6_blocks_in", n_in, NSTREAM);
    repeat (NBEATS + 2) @(posedge clk);
    #1;
    chk_bit("t6_no_extra_output", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
